// File: rtl/regfile_operand_stage.sv
// Operand-fetch stage: 32x32 register file with one-hot read selects,
// same-cycle writeback bypass, immediate substitution on B, and a
// registered hand-off of operands and pass-through controls to execute.
module regfile_operand_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      ibus,
  input  logic [NREGS-1:0] Aselect,
  input  logic [NREGS-1:0] Bselect,
  input  logic [NREGS-1:0] Dselect,
  input  logic             Imm,
  input  logic [2:0]       S,
  input  logic             Cin,
  input  logic             stall,
  input  logic [NREGS-1:0] wb_Dselect,
  input  logic [WIDTH-1:0] wb_dbus,
  output logic [WIDTH-1:0] abus,
  output logic [WIDTH-1:0] bbus,
  output logic [NREGS-1:0] Dselect_out,
  output logic [2:0]       S_out,
  output logic             Cin_out,
  output logic             Imm_out
);

  // r0 has no storage; it is hard-wired to read zero.
  logic [WIDTH-1:0] regs [1:NREGS-1];

  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic [WIDTH-1:0] immx;
  logic [WIDTH-1:0] bnext;

  // Upper instruction bits and the r0 write flag carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{ibus[31:16], wb_Dselect[0]};

  // Writeback port: every flagged register (except r0) loads wb_dbus.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        if (wb_Dselect[i]) begin
          regs[i] <= wb_dbus;
        end
      end
    end
  end

  // Wired-OR reads, with a same-cycle writeback replacing the stored value.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (Aselect[i]) begin
        rd_a = rd_a | (wb_Dselect[i] ? wb_dbus : regs[i]);
      end
      if (Bselect[i]) begin
        rd_b = rd_b | (wb_Dselect[i] ? wb_dbus : regs[i]);
      end
    end
  end

  assign immx  = {{(WIDTH-16){ibus[15]}}, ibus[15:0]};
  assign bnext = Imm ? immx : rd_b;

  // Pipeline register toward execute; holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      abus        <= '0;
      bbus        <= '0;
      Dselect_out <= '0;
      S_out       <= '0;
      Cin_out     <= 1'b0;
      Imm_out     <= 1'b0;
    end else if (!stall) begin
      abus        <= rd_a;
      bbus        <= bnext;
      Dselect_out <= Dselect;
      S_out       <= S;
      Cin_out     <= Cin;
      Imm_out     <= Imm;
    end
  end

endmodule

// File: doc/regfile_operand_stage.md
# regfile_operand_stage

Operand-fetch stage sitting directly downstream of the instruction-decode stage. Takes the registered one-hot `Aselect`/`Bselect`/`Dselect` selects, the `Imm`/`S`/`Cin` controls and the decoded instruction word. Reads two operands from a 32x32 register file, substitutes the sign-extended immediate for the B operand when `Imm` is set, and registers everything for the ALU/execute stage. Also hosts the register-file write port used by writeback.

## Interface
- `WIDTH`, 32, data and register width; fixed at 32.
- `NREGS`, 32, number of registers; equals the one-hot select width.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high; sampled on posedge `clk`.
- `ibus`  in  32  instruction word aligned with the selects; only `ibus[15:0]` is used (immediate).
- `Aselect`  in  32  one-hot read select, port A.
- `Bselect`  in  32  one-hot read select, port B.
- `Dselect`  in  32  one-hot destination select, passed through.
- `Imm`  in  1  1 = B operand is the immediate.
- `S`  in  3  ALU function code, passed through.
- `Cin`  in  1  ALU carry-in, passed through.
- `stall`  in  1  1 = hold all output registers.
- `wb_Dselect`  in  32  one-hot writeback destination; all-zero = no write.
- `wb_dbus`  in  32  writeback data.
- `abus`  out  32  registered A operand.
- `bbus`  out  32  registered B operand or immediate.
- `Dselect_out`  out  32  registered destination select.
- `S_out`  out  3  registered ALU function.
- `Cin_out`  out  1  registered carry-in.
- `Imm_out`  out  1  registered immediate flag.

## Operation
- Register file: r0..r31, 32 bits each. r0 always reads 0 and is never written; `wb_Dselect[0]` is ignored.
- Write: on posedge with `reset`=0, every register `i` (i≥1) with `wb_Dselect[i]`=1 loads `wb_dbus`. A multi-hot write writes all flagged registers. Writes are independent of `stall`.
- Read: `rdA` = bitwise OR of all registers whose `Aselect` bit is set; likewise `rdB`. This gives wired-OR bus semantics: all-zero select reads 0, and multi-hot reads OR the values.
- Bypass: if `wb_Dselect[i]`=1 and `Aselect[i]`=1 for some i≥1 in the same cycle, `wb_dbus` is used in place of r_i's stored value. Same rule for B. The stage therefore never reads stale data for a same-cycle writeback.
- Immediate: `immx` = {{16{ibus[15]}}, ibus[15:0]}.
- B mux: `bnext` = `Imm` ? `immx` : `rdB`.
- Output registers capture `rdA`, `bnext`, `Dselect`, `S`, `Cin` and `Imm` on posedge when `stall`=0 and `reset`=0. When `stall`=1 they hold.
- Reset: all 31 writable registers clear to 0; all outputs clear to 0 (`abus`, `bbus`, `Dselect_out` = 32'h0, `S_out` = 3'b000, `Cin_out` = 0, `Imm_out` = 0).
- Priority: `reset` > writes/`stall`. A writeback presented in a reset cycle is discarded. Reset mid-stall clears outputs and releases nothing pending.

## Timing
- Latency: selects/controls presented in cycle N appear on outputs after posedge N+1 (1 cycle), matching the decode stage's cadence.
- Write-to-read: a write on posedge N is visible to reads presented in cycle N via bypass, and from storage from cycle N+1 onward.
- No handshake beyond `stall`. Upstream must hold its inputs while `stall`=1; the block does not buffer.
- Pass-through fields (`Dselect`, `S`, `Cin`, `Imm`) are not modified.
- Operand reads are purely combinational from storage or bypass into the output registers; no combinational input-to-output path.

## Test plan
- Reset then idle: assert `reset` one cycle with `wb_Dselect`=32'h4 -> all outputs 0; r2 still reads 0 afterwards.
- Write/read: write r5=32'hDEADBEEF, next cycle `Aselect`=32'h20, `Bselect`=32'h1, `Imm`=0 -> one cycle later `abus`=32'hDEADBEEF, `bbus`=0.
- Immediate: `Imm`=1, `ibus[15:0]`=16'hFFF0, `S`=3'b010 -> `bbus`=32'hFFFFFFF0, `S_out`=3'b010, `Imm_out`=1.
- Bypass: same cycle `wb_Dselect`=32'h100, `wb_dbus`=32'h12345678, `Aselect`=32'h100 -> next cycle `abus`=32'h12345678.
- r0 protection: write `wb_Dselect`=32'h1 with data 32'hFFFFFFFF, then read `Aselect`=32'h1 -> `abus`=0.
- Stall: load outputs, assert `stall` 3 cycles while changing inputs and writing r7=32'h77 -> outputs unchanged. Release `stall` with `Aselect`=32'h80 -> `abus`=32'h77 next cycle.
